rtc_bus_responder: RTL and testbench
====================================

Name: rtc_bus_responder

Overview:
- Responder (RTC-chip side) of the multiplexed address/data bus that the team's RTC initializer and readers drive through CS/AD/RD/WR plus an 8-bit AD bus.
- Decodes the address phase, then services write and read cycles against an internal register file.
- Used as a synthesizable RTC stand-in for on-board loopback and as the bus-compliance checker.
- Write events are exported so downstream logic can observe init traffic, e.g. the 0x21–0x26 and 0x41–0x43 sequence.

Parameters:
- REG_DEPTH, 128: number of 8-bit registers, addresses 0..REG_DEPTH-1.
- SYNC_STAGES, 2: synchronizer depth applied to strobes and the AD bus alike; minimum 2.
- RESET_VAL, 8'h00: reset content of every register.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- cs_n  in  1  chip select, active low.
- ad_n  in  1  address strobe, active low; low marks the address phase.
- rd_n  in  1  read strobe, active low.
- wr_n  in  1  write strobe, active low.
- ad_in  in  8  AD bus as driven by the initiator.
- ad_out  out  8  read data driven toward the AD bus.
- ad_oe  out  1  bus drive enable for ad_out.
- wr_pulse  out  1  one-cycle pulse on each committed write.
- wr_addr  out  8  address of the last committed write.
- wr_data  out  8  data of the last committed write.
- err  out  1  one-cycle protocol/range error pulse.
- loc_addr  in  8  local read-port address.
- loc_data  out  8  registered register-file content at loc_addr, 1-cycle latency; 0x00 if out of range.

Behaviour:
- Reset (async assert):
  - Register file = RESET_VAL; addr = 0; state = IDLE.
  - All outputs 0.
  - Synchronizer flops load 1 for the strobes and 0 for the bus.
  - Reset deassertion is consumed on the next clk edge.
- Sampling: all strobe and bus decisions use synchronized values, so each decision lags the pins by SYNC_STAGES cycles. "Rise" means synced 0→1 between consecutive cycles.
- State machine: IDLE, ADDR, ARMED, WR, RD.
- IDLE: cs_n=0 and ad_n=0 → ADDR.
- ADDR:
  - ad_n rise with cs_n=0 → addr = ad_in sampled in the last low cycle; → ARMED.
  - cs_n=1 before ad_n rises → IDLE; addr unchanged.
- ARMED (addr retained until the next address phase, across cs_n deassertion):
  - cs_n=0 and ad_n=0 → ADDR.
  - cs_n=0, wr_n=0, rd_n=1 → WR.
  - cs_n=0, rd_n=0, wr_n=1 → RD.
  - rd_n=0 and wr_n=0 together → err pulse; stay ARMED; no access.
- WR:
  - wr_n rise → capture ad_in from the last low cycle.
    - If addr<REG_DEPTH: reg[addr] written, wr_pulse=1, wr_addr/wr_data updated in the same cycle.
    - Otherwise: err=1 and the write is dropped.
    - Either way → ARMED.
  - cs_n=1, ad_n=0 or rd_n=0 before the wr_n rise → abort: no write, err=1, → ARMED.
- RD:
  - Entry cycle: ad_out = reg[addr], or 0x00 with err=1 if out of range.
  - ad_oe=1 from the cycle after entry.
  - rd_n rise or cs_n=1 → ad_oe=0 in that same cycle; → ARMED.
  - ad_n=0 or wr_n=0 during RD → ad_oe=0, err=1, → ARMED.
- ad_out holds its last value when ad_oe=0; ad_oe never overlaps WR.
- Reset mid-cycle: any access in progress is discarded and ad_oe drops asynchronously.
- Local port:
  - Reads the register file with no interaction with bus states.
  - Same-cycle bus write and local read of the same address → loc_data returns old data; the new value appears the next cycle.
- Address is 8 bits wide; no truncation to REG_DEPTH; out-of-range handling as above.

Optional Feature:
- Macro RTC_BUS_AUTO_INC_EN.
- Defined: after each completed in-range WR or RD, addr increments by 1, wrapping REG_DEPTH-1 → 0. Aborted or out-of-range accesses do not increment.
- Undefined: addr changes only in the address phase; repeated data cycles hit the same register.

Test Plan:
- Address 0x21, write 0x00, then read 0x21 → wr_pulse once with wr_addr=0x21, wr_data=0x00; read ad_out=0x00, ad_oe high only while rd_n is low (+sync lag).
- Address 0x24, write 0x01; loc_addr=0x24 → loc_data=0x01 one cycle after the write commits; the value before commit is 0x00.
- Address 0x90 with REG_DEPTH=128, write 0x55 → err pulse, no wr_pulse; a following read of 0x90 → ad_out=0x00, err pulse.
- rd_n and wr_n driven low together in ARMED → single err pulse, ad_oe stays 0, register file unchanged.
- Reset asserted while rd_n is low mid-read → ad_oe=0 immediately, all registers=0x00, state IDLE after release.
- With RTC_BUS_AUTO_INC_EN: address 0x7F, write 0xAA, then write 0xBB without re-addressing → reg[0x7F]=0xAA, reg[0x00]=0xBB. Without the macro: reg[0x7F]=0xBB.

Source files
------------

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: RTC-side responder for the CS/AD/RD/WR multiplexed bus with a local read port.
// Optional macro RTC_BUS_AUTO_INC_EN: advance the address after each completed in-range data cycle.
module rtc_bus_responder #(
    parameter int         REG_DEPTH   = 128,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       ad_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       wr_pulse,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       err,
    input  logic [7:0] loc_addr,
    output logic [7:0] loc_data
);
    localparam int         AW    = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [8:0] DEPTH = 9'(REG_DEPTH);

    typedef enum logic [2:0] {IDLE, ADDR, ARMED, WR, RD} state_t;

    logic [3:0] stb_q [SYNC_STAGES];
    logic [3:0] stb_d [SYNC_STAGES];
    logic [7:0] bus_q [SYNC_STAGES];
    logic [7:0] bus_d [SYNC_STAGES];
    logic [2:0] prev_q, prev_d;
    logic [7:0] bus_prev_q, bus_prev_d;
    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] mem_q [REG_DEPTH];
    logic [7:0] mem_d [REG_DEPTH];
    logic [7:0] ad_out_q, ad_out_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, loc_data_q, loc_data_d;
    logic       ad_oe_q, ad_oe_d, wr_pulse_q, wr_pulse_d, err_q, err_d;
    logic       cs, ad, rd, wr, ad_rise, rd_rise, wr_rise, addr_ok, loc_ok;
    logic [AW-1:0] idx;

    assign {cs, ad, rd, wr} = stb_q[SYNC_STAGES-1];
    assign ad_rise = ad & ~prev_q[2];
    assign rd_rise = rd & ~prev_q[1];
    assign wr_rise = wr & ~prev_q[0];
    assign addr_ok = {1'b0, addr_q} < DEPTH;
    assign loc_ok  = {1'b0, loc_addr} < DEPTH;
    assign idx     = addr_q[AW-1:0];

    // Synchronizer chain for strobes and bus, plus one cycle of history for edge detection.
    always_comb begin
        stb_d[0] = {cs_n, ad_n, rd_n, wr_n};
        bus_d[0] = ad_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stb_d[i] = stb_q[i-1];
            bus_d[i] = bus_q[i-1];
        end
        prev_d     = stb_q[SYNC_STAGES-1][2:0];
        bus_prev_d = bus_q[SYNC_STAGES-1];
    end

    // Bus state machine, register-file update and local read port.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_d      = mem_q;
        ad_out_d   = ad_out_q;
        ad_oe_d    = 1'b0;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = 1'b0;
        loc_data_d = loc_ok ? mem_q[loc_addr[AW-1:0]] : 8'h00;
        case (state_q)
            IDLE: state_d = (!cs && !ad) ? ADDR : IDLE;
            ADDR: begin
                if (cs) begin
                    state_d = IDLE;
                end else if (ad_rise) begin
                    addr_d  = bus_prev_q;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!cs && !ad) begin
                    state_d = ADDR;
                end else if (!rd && !wr) begin
                    err_d = prev_q[1] | prev_q[0];
                end else if (!cs && !wr) begin
                    state_d = WR;
                end else if (!cs && !rd) begin
                    state_d  = RD;
                    ad_out_d = addr_ok ? mem_q[idx] : 8'h00;
                    err_d    = !addr_ok;
                end
            end
            WR: begin
                if (cs || !ad || !rd) begin
                    err_d   = 1'b1;
                    state_d = ARMED;
                end else if (wr_rise) begin
                    state_d = ARMED;
                    err_d   = !addr_ok;
                    if (addr_ok) begin
                        mem_d[idx] = bus_prev_q;
                        wr_pulse_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = bus_prev_q;
`ifdef RTC_BUS_AUTO_INC_EN
                        addr_d     = (addr_q == 8'(REG_DEPTH-1)) ? 8'h00 : addr_q + 8'h01;
`endif
                    end
                end
            end
            RD: begin
                if (!ad || !wr) begin
                    err_d   = 1'b1;
                    state_d = ARMED;
                end else if (rd_rise || cs) begin
                    state_d = ARMED;
`ifdef RTC_BUS_AUTO_INC_EN
                    if (addr_ok) addr_d = (addr_q == 8'(REG_DEPTH-1)) ? 8'h00 : addr_q + 8'h01;
`endif
                end else begin
                    ad_oe_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset also drops ad_oe asynchronously and clears the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stb_q[i] <= 4'hF;
                bus_q[i] <= 8'h00;
            end
            for (int i = 0; i < REG_DEPTH; i++) mem_q[i] <= RESET_VAL;
            prev_q     <= 3'b111;
            bus_prev_q <= 8'h00;
            state_q    <= IDLE;
            addr_q     <= 8'h00;
            ad_out_q   <= 8'h00;
            ad_oe_q    <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            err_q      <= 1'b0;
            loc_data_q <= 8'h00;
        end else begin
            stb_q      <= stb_d;
            bus_q      <= bus_d;
            mem_q      <= mem_d;
            prev_q     <= prev_d;
            bus_prev_q <= bus_prev_d;
            state_q    <= state_d;
            addr_q     <= addr_d;
            ad_out_q   <= ad_out_d;
            ad_oe_q    <= ad_oe_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
            loc_data_q <= loc_data_d;
        end
    end

    assign ad_out   = ad_out_q;
    assign ad_oe    = ad_oe_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign err      = err_q;
    assign loc_data = loc_data_q;
endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb_rtc_bus_responder: table-driven bus transactions plus directed corner sequences for rtc_bus_responder.
module tb_rtc_bus_responder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cs_n = 1'b1, ad_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0] ad_in = 8'h00, loc_addr = 8'h00;
    logic [7:0] ad_out, wr_addr, wr_data, loc_data;
    logic       ad_oe, wr_pulse, err;

    rtc_bus_responder dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .ad_n(ad_n), .rd_n(rd_n), .wr_n(wr_n),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .wr_pulse(wr_pulse),
        .wr_addr(wr_addr), .wr_data(wr_data), .err(err), .loc_addr(loc_addr), .loc_data(loc_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int n_wp = 0, n_err = 0, n_oe = 0;
    logic [7:0] last_wa = 8'h00, last_wd = 8'h00, last_rd = 8'h00;

    // Cumulative event monitor sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (wr_pulse) begin
            n_wp++;
            last_wa = wr_addr;
            last_wd = wr_data;
        end
        if (err) n_err++;
        if (ad_oe) begin
            n_oe++;
            last_rd = ad_out;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_addr(input logic [7:0] a);
        cs_n = 1'b0; ad_n = 1'b0; ad_in = a;
        hold(4);
        ad_n = 1'b1;
        hold(4);
    endtask

    task automatic bus_wr(input logic [7:0] d);
        wr_n = 1'b0; ad_in = d;
        hold(4);
        wr_n = 1'b1;
        hold(4);
    endtask

    task automatic bus_rd();
        rd_n = 1'b0;
        hold(5);
        rd_n = 1'b1;
        hold(4);
    endtask

    task automatic bus_end();
        cs_n = 1'b1;
        hold(4);
    endtask

    task automatic loc_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
        loc_addr = a;
        hold(2);
        chk(nm, int'(loc_data), int'(exp));
    endtask

    typedef struct {
        bit         is_rd;
        logic [7:0] a;
        logic [7:0] d;
        int         wp;
        int         er;
        logic [7:0] rdv;
    } vec_t;

    vec_t v [10];

    initial begin
        int wp0, er0, oe0;
        bit seen;
        v[0] = '{1'b0, 8'h21, 8'h00, 1, 0, 8'h00};
        v[1] = '{1'b1, 8'h21, 8'h00, 0, 0, 8'h00};
        v[2] = '{1'b0, 8'h24, 8'h01, 1, 0, 8'h00};
        v[3] = '{1'b1, 8'h24, 8'h00, 0, 0, 8'h01};
        v[4] = '{1'b0, 8'h90, 8'h55, 0, 1, 8'h00};
        v[5] = '{1'b1, 8'h90, 8'h00, 0, 1, 8'h00};
        v[6] = '{1'b0, 8'h7F, 8'hAA, 1, 0, 8'h00};
        v[7] = '{1'b1, 8'h7F, 8'h00, 0, 0, 8'hAA};
        v[8] = '{1'b0, 8'h00, 8'h5A, 1, 0, 8'h00};
        v[9] = '{1'b1, 8'h00, 8'h00, 0, 0, 8'h5A};

        hold(3);
        chk("rst ad_out", int'(ad_out), 0);
        chk("rst ad_oe", int'(ad_oe), 0);
        chk("rst wr_pulse", int'(wr_pulse), 0);
        chk("rst wr_addr", int'(wr_addr), 0);
        chk("rst wr_data", int'(wr_data), 0);
        chk("rst err", int'(err), 0);
        chk("rst loc_data", int'(loc_data), 0);
        reset = 1'b1;
        hold(3);

        for (int i = 0; i < 10; i++) begin
            wp0 = n_wp; er0 = n_err; oe0 = n_oe;
            bus_addr(v[i].a);
            if (v[i].is_rd) bus_rd();
            else bus_wr(v[i].d);
            bus_end();
            chk($sformatf("v%0d wr_pulse count", i), n_wp - wp0, v[i].wp);
            chk($sformatf("v%0d err count", i), n_err - er0, v[i].er);
            if (!v[i].is_rd && v[i].wp > 0) begin
                chk($sformatf("v%0d wr_addr", i), int'(last_wa), int'(v[i].a));
                chk($sformatf("v%0d wr_data", i), int'(last_wd), int'(v[i].d));
            end
            if (v[i].is_rd) begin
                chk($sformatf("v%0d ad_oe seen", i), int'(n_oe > oe0), 1);
                chk($sformatf("v%0d ad_out", i), int'(last_rd), int'(v[i].rdv));
                chk($sformatf("v%0d ad_oe after rd", i), int'(ad_oe), 0);
            end else begin
                chk($sformatf("v%0d ad_oe during wr", i), n_oe - oe0, 0);
            end
        end

        loc_addr = 8'h30;
        bus_addr(8'h30);
        wr_n = 1'b0; ad_in = 8'h77;
        hold(4);
        wr_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (wr_pulse) begin
                seen = 1'b1;
                chk("loc old at commit", int'(loc_data), 8'h00);
                @(negedge clk);
                chk("loc new after commit", int'(loc_data), 8'h77);
            end
        end
        chk("loc commit seen", int'(seen), 1);
        hold(2);
        bus_end();

        wp0 = n_wp; er0 = n_err; oe0 = n_oe;
        bus_addr(8'h24);
        rd_n = 1'b0; wr_n = 1'b0;
        hold(4);
        rd_n = 1'b1; wr_n = 1'b1;
        hold(4);
        bus_end();
        chk("both-low err", n_err - er0, 1);
        chk("both-low ad_oe", n_oe - oe0, 0);
        chk("both-low wr_pulse", n_wp - wp0, 0);
        loc_chk("both-low reg 0x24", 8'h24, 8'h01);

        bus_addr(8'h24);
        rd_n = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            seen = ad_oe;
        end
        chk("mid-read ad_oe up", int'(seen), 1);
        #2 reset = 1'b0;
        #1 chk("reset ad_oe drop", int'(ad_oe), 0);
        @(negedge clk);
        rd_n = 1'b1; cs_n = 1'b1;
        hold(2);
        reset = 1'b1;
        hold(3);
        loc_chk("post-rst reg 0x24", 8'h24, 8'h00);
        loc_chk("post-rst reg 0x7F", 8'h7F, 8'h00);
        loc_chk("post-rst reg 0x30", 8'h30, 8'h00);
        wp0 = n_wp; er0 = n_err; oe0 = n_oe;
        cs_n = 1'b0; rd_n = 1'b0;
        hold(6);
        rd_n = 1'b1;
        hold(4);
        bus_end();
        chk("idle ignores rd", n_oe - oe0, 0);
        chk("idle no err", n_err - er0, 0);

        bus_addr(8'h7F);
        bus_wr(8'hAA);
        bus_wr(8'hBB);
        bus_end();
`ifdef RTC_BUS_AUTO_INC_EN
        loc_chk("autoinc reg 0x7F", 8'h7F, 8'hAA);
        loc_chk("autoinc reg 0x00", 8'h00, 8'hBB);
`else
        loc_chk("noinc reg 0x7F", 8'h7F, 8'hBB);
        loc_chk("noinc reg 0x00", 8'h00, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
